axi_lite_slave_mem: RTL and testbench
=====================================

// Module: axi_lite_slave_mem
// PURPOSE
//  AXI4-Lite responder backed by a byte-wide on-chip memory. It is the far end of the
//  interconnect: it accepts AW/W/AR from a master and returns B/R. It is the reference
//  target for master and scoreboard checks. One write and one read may be outstanding at
//  a time, and the two paths run independently.
// PARAMETERS
//  MEM_DEPTH  BUFFER_SIZE (4096)  number of DATA_WIDTH-bit words; addresses >= MEM_DEPTH decode-error
// PORTS
//  ACLK     in   1           clock; all logic on rising edge
//  ARESET   in   1           asynchronous, active-high reset
//  AWADDR   in   ADDR_WIDTH  write address (12)
//  AWVALID  in   1           write address valid
//  AWREADY  out  1           write address ready
//  WDATA    in   DATA_WIDTH  write data (8)
//  WSTRB    in   STRB_WIDTH  byte strobe (1)
//  WVALID   in   1           write data valid
//  WREADY   out  1           write data ready
//  BRESP    out  2           write response
//  BVALID   out  1           write response valid
//  BREADY   in   1           write response ready
//  ARADDR   in   ADDR_WIDTH  read address
//  ARVALID  in   1           read address valid
//  ARREADY  out  1           read address ready
//  RDATA    out  DATA_WIDTH  read data
//  RRESP    out  2           read response
//  RVALID   out  1           read data valid
//  RREADY   in   1           read data ready
// BEHAVIOUR
//  Reset: all outputs 0: AWREADY, WREADY, ARREADY, BVALID, RVALID, RDATA, BRESP, RRESP.
//   Memory contents are not cleared. Readies rise on the first clock edge after ARESET deasserts.
//   ARESET mid-transaction aborts it. No B/R is issued for the aborted transaction, and any
//   write not yet committed is dropped.
//  Write FSM, states WR_ADDR_DATA -> WR_RESP -> WR_ADDR_DATA:
//   - WR_ADDR_DATA: AWREADY = !aw_held and WREADY = !w_held, both registered. AW and W are
//     captured independently, in either order or in the same cycle.
//   - Commit happens on the edge where both are held. If addr < MEM_DEPTH, mem[addr] <= WDATA
//     when WSTRB[0]=1, and BRESP = RESP_OKAY. Otherwise there is no write and BRESP = RESP_DECERR.
//   - WSTRB = 0 means no write and BRESP = RESP_OKAY.
//   - The commit edge moves the FSM to WR_RESP and sets BVALID=1 on the following cycle.
//     Latency is 1 cycle from the later of the two handshakes to BVALID.
//   - WR_RESP: AWREADY = WREADY = 0. BVALID and BRESP are held stable until BREADY.
//     The B handshake clears the held flags and returns to WR_ADDR_DATA, with readies high
//     the next cycle.
//  Read FSM, states RD_ADDR -> RD_DATA -> RD_ADDR:
//   - RD_ADDR: ARREADY = 1. On the AR handshake, RDATA/RRESP are registered and RVALID=1
//     the next cycle (1-cycle latency).
//   - Out-of-range addr returns RDATA = 0 and RRESP = RESP_DECERR.
//   - RD_DATA: ARREADY = 0. RVALID, RDATA and RRESP are stable until RREADY; the handshake
//     returns to RD_ADDR.
//  Simultaneous events:
//   - Read and write commit to the same addr on the same edge: the read returns OLD data
//     (read-before-write).
//   - AR and AW/W in the same cycle are both accepted; the paths never stall each other.
//  Addresses are word indices: no alignment checks and no wrap.
//   Address compare is width-exact: ADDR_WIDTH-bit unsigned against MEM_DEPTH.
//  RESP_SLVERR and RESP_EXOKAY are never generated.
// STRUCTURE
//  axi_lite_pkg provides ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, addr_t/data_t/strb_t/resp_t,
//   RESP_* and BUFFER_SIZE. The FSM state enums (wr_state_t, rd_state_t) are added to the
//   package for bench visibility.
//  Sub-module axi_lite_mem_array(MEM_DEPTH) is a 1W/1R synchronous RAM with write enable and
//   read-before-write. The top holds only the two FSMs, the AW/W holding registers and the
//   decode compare.
// TESTING
//  1. Write: AW 0x010 and W 0xA5 in the same cycle, BREADY=1
//     -> BVALID one cycle later, BRESP=00.
//     Then read 0x010 -> RVALID one cycle after the AR handshake, RDATA=0xA5, RRESP=00.
//  2. AW 0x020 given 3 cycles before W 0x3C
//     -> AWREADY drops after the AW capture, BVALID only after W is accepted.
//     Readback of 0x020 = 0x3C.
//  3. MEM_DEPTH=2048: write 0x800 = 0xFF -> BRESP=11, mem unchanged.
//     Read 0x800 -> RDATA=0x00, RRESP=11.
//  4. Backpressure: hold BREADY=0 and RREADY=0 for 5 cycles
//     -> BVALID/RVALID and payloads stable, AWREADY/WREADY/ARREADY=0.
//     Release -> readies return the next cycle.
//  5. WSTRB=0 write of 0x77 to 0x005 (prior value 0x12) -> BRESP=00, readback 0x12.
//     Same-edge read/write of 0x005 with 0x99 -> read returns 0x12, later read returns 0x99.
//  6. Assert ARESET while BVALID=1 and RVALID=1
//     -> all outputs 0 asynchronously, readies high one edge after release, no stale B/R.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types, widths and response codes for the AXI4-Lite memory responder.
package axi_lite_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int DATA_WIDTH  = 8;
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int BUFFER_SIZE = 4096;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;
    typedef logic [1:0]            resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_EXOKAY = 2'b01;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    typedef enum logic {
        WR_ADDR_DATA = 1'b0,
        WR_RESP      = 1'b1
    } wr_state_t;

    typedef enum logic {
        RD_ADDR = 1'b0,
        RD_DATA = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi_lite_mem_array.sv
// One-write / one-read synchronous byte RAM. A read and a write to the same
// word on the same edge return the old contents (read-before-write).
module axi_lite_mem_array
    import axi_lite_pkg::*;
#(
    parameter int MEM_DEPTH = BUFFER_SIZE,
    parameter int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  data_t            wr_data,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_addr,
    output data_t            rd_data
);

    data_t mem_q [MEM_DEPTH];
    data_t rd_data_q;
    data_t rd_data_d;

    // Storage is deliberately left out of reset so contents survive ARESET.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next read word: load on a read enable, otherwise hold the last result.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_addr];
        end
    end

    // Read output register; cleared by reset so the read data port starts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite responder backed by a byte memory. Independent write and read
// FSMs, each allowing one outstanding transaction.
module axi_lite_slave_mem
    import axi_lite_pkg::*;
#(
    parameter int MEM_DEPTH = BUFFER_SIZE
) (
    input  logic  ACLK,
    input  logic  ARESET,
    input  addr_t AWADDR,
    input  logic  AWVALID,
    output logic  AWREADY,
    input  data_t WDATA,
    input  strb_t WSTRB,
    input  logic  WVALID,
    output logic  WREADY,
    output resp_t BRESP,
    output logic  BVALID,
    input  logic  BREADY,
    input  addr_t ARADDR,
    input  logic  ARVALID,
    output logic  ARREADY,
    output data_t RDATA,
    output resp_t RRESP,
    output logic  RVALID,
    input  logic  RREADY
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    // Width-exact decode: the address is zero-extended by one bit so a depth of
    // exactly 2**ADDR_WIDTH still compares correctly.
    function automatic logic in_range(input addr_t a);
        return ({1'b0, a} < DEPTH_LIM);
    endfunction

    wr_state_t wr_state_q, wr_state_d;
    logic      aw_held_q, aw_held_d;
    logic      w_held_q, w_held_d;
    addr_t     awaddr_q, awaddr_d;
    data_t     wdata_q, wdata_d;
    strb_t     wstrb_q, wstrb_d;
    logic      awready_q, awready_d;
    logic      wready_q, wready_d;
    logic      bvalid_q, bvalid_d;
    resp_t     bresp_q, bresp_d;
    logic      mem_we;

    rd_state_t rd_state_q, rd_state_d;
    logic      arready_q, arready_d;
    logic      rvalid_q, rvalid_d;
    resp_t     rresp_q, rresp_d;
    logic      mem_re;
    data_t     mem_rdata;

    // Write path: capture AW and W independently, commit once both are held,
    // then hold the B response until the master accepts it.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        mem_we     = 1'b0;
        case (wr_state_q)
            WR_ADDR_DATA: begin
                if (AWVALID && awready_q) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = AWADDR;
                end
                if (WVALID && wready_q) begin
                    w_held_d = 1'b1;
                    wdata_d  = WDATA;
                    wstrb_d  = WSTRB;
                end
                if (aw_held_d && w_held_d) begin
                    wr_state_d = WR_RESP;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    bvalid_d   = 1'b1;
                    if (in_range(awaddr_d)) begin
                        bresp_d = RESP_OKAY;
                        mem_we  = wstrb_d[0];
                    end else begin
                        bresp_d = RESP_DECERR;
                    end
                end else begin
                    awready_d = !aw_held_d;
                    wready_d  = !w_held_d;
                end
            end
            WR_RESP: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (BREADY) begin
                    bvalid_d   = 1'b0;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_ADDR_DATA;
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                end
            end
            default: begin
                wr_state_d = WR_ADDR_DATA;
            end
        endcase
    end

    // Write path registers; reset drops any half-captured write and pending response.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_state_q <= WR_ADDR_DATA;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    // Read path: accept an address, present data one cycle later, hold until taken.
    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        mem_re     = 1'b0;
        case (rd_state_q)
            RD_ADDR: begin
                arready_d = 1'b1;
                if (ARVALID && arready_q) begin
                    rd_state_d = RD_DATA;
                    arready_d  = 1'b0;
                    rvalid_d   = 1'b1;
                    if (in_range(ARADDR)) begin
                        rresp_d = RESP_OKAY;
                        mem_re  = 1'b1;
                    end else begin
                        rresp_d = RESP_DECERR;
                    end
                end
            end
            RD_DATA: begin
                arready_d = 1'b0;
                if (RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = RD_ADDR;
                    arready_d  = 1'b1;
                end
            end
            default: begin
                rd_state_d = RD_ADDR;
            end
        endcase
    end

    // Read path registers; reset abandons any response that has not been taken.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rd_state_q <= RD_ADDR;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
        end
    end

    axi_lite_mem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk     (ACLK),
        .rst     (ARESET),
        .wr_en   (mem_we),
        .wr_addr (awaddr_d[IDX_W-1:0]),
        .wr_data (wdata_d),
        .rd_en   (mem_re),
        .rd_addr (ARADDR[IDX_W-1:0]),
        .rd_data (mem_rdata)
    );

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    // A decode error read never loads the RAM register, so its data is forced to zero here.
    assign RDATA   = (rresp_q == RESP_OKAY) ? mem_rdata : '0;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Self-checking bench for axi_lite_slave_mem: transaction-level reference
// model, per-cycle compare process, directed scenarios and random traffic.
module tb_axi_lite_slave_mem;

    localparam int DEPTH = 2048;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [7:0]  WDATA = '0;
    logic [0:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [11:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [7:0]  RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b1;

    int checks = 0;
    int failures = 0;

    axi_lite_slave_mem #(.MEM_DEPTH(DEPTH)) dut (
        .ACLK    (clock),
        .ARESET  (reset),
        .AWADDR  (AWADDR),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WSTRB   (WSTRB),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BRESP   (BRESP),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .ARADDR  (ARADDR),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RVALID  (RVALID),
        .RREADY  (RREADY)
    );

    always #5 clock = ~clock;

    // Reference model state: what the responder owes the master, not how it is built.
    logic [7:0]  mdl_mem [DEPTH];
    bit          mdl_known [DEPTH];
    bit          started = 0;
    bit          b_owed = 0;
    bit          r_owed = 0;
    bit          aw_got = 0;
    bit          w_got = 0;
    logic [11:0] got_addr = '0;
    logic [7:0]  got_data = '0;
    logic        got_strb = 1'b0;
    logic [1:0]  exp_bresp = 2'b00;
    logic [1:0]  exp_rresp = 2'b00;
    logic [7:0]  exp_rdata = '0;
    bit          exp_rknown = 1;
    bit          m_aw_hs, m_w_hs, m_ar_hs, m_b_hs, m_r_hs;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s: handshake never completed, expected within bound at %0t", name, $time);
    endtask

    // Model update on each clock edge: handshakes follow from what the model says is ready.
    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                started = 0;
                b_owed  = 0;
                r_owed  = 0;
                aw_got  = 0;
                w_got   = 0;
            end else begin
                m_aw_hs = AWVALID && started && !b_owed && !aw_got;
                m_w_hs  = WVALID && started && !b_owed && !w_got;
                m_ar_hs = ARVALID && started && !r_owed;
                m_b_hs  = b_owed && BREADY;
                m_r_hs  = r_owed && RREADY;
                if (m_r_hs) r_owed = 0;
                if (m_ar_hs) begin
                    r_owed = 1;
                    if (ARADDR < DEPTH) begin
                        exp_rresp  = 2'b00;
                        exp_rdata  = mdl_mem[ARADDR[10:0]];
                        exp_rknown = mdl_known[ARADDR[10:0]];
                    end else begin
                        exp_rresp  = 2'b11;
                        exp_rdata  = 8'h00;
                        exp_rknown = 1;
                    end
                end
                if (m_b_hs) b_owed = 0;
                if (m_aw_hs) begin
                    aw_got   = 1;
                    got_addr = AWADDR;
                end
                if (m_w_hs) begin
                    w_got    = 1;
                    got_data = WDATA;
                    got_strb = WSTRB[0];
                end
                if (aw_got && w_got) begin
                    b_owed = 1;
                    aw_got = 0;
                    w_got  = 0;
                    if (got_addr < DEPTH) begin
                        exp_bresp = 2'b00;
                        if (got_strb) begin
                            mdl_mem[got_addr[10:0]]   = got_data;
                            mdl_known[got_addr[10:0]] = 1;
                        end
                    end else begin
                        exp_bresp = 2'b11;
                    end
                end
                started = 1;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                check_output("rst_awready", AWREADY, 0);
                check_output("rst_wready", WREADY, 0);
                check_output("rst_arready", ARREADY, 0);
                check_output("rst_bvalid", BVALID, 0);
                check_output("rst_rvalid", RVALID, 0);
                check_output("rst_bresp", BRESP, 0);
                check_output("rst_rresp", RRESP, 0);
                check_output("rst_rdata", RDATA, 0);
            end else begin
                check_output("awready", AWREADY, started && !b_owed && !aw_got);
                check_output("wready", WREADY, started && !b_owed && !w_got);
                check_output("arready", ARREADY, started && !r_owed);
                check_output("bvalid", BVALID, b_owed);
                check_output("rvalid", RVALID, r_owed);
                if (b_owed) check_output("bresp", BRESP, exp_bresp);
                if (r_owed) check_output("rresp", RRESP, exp_rresp);
                if (r_owed && exp_rknown) check_output("rdata", RDATA, exp_rdata);
            end
        end
    end

    // Channel drivers: raise valid on a falling edge, drop it after the accepting edge.
    task automatic send_aw(input logic [11:0] a);
        int n;
        n = 0;
        AWADDR  = a;
        AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) fail_timeout("aw_timeout");
        @(negedge clock);
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [7:0] d, input logic s);
        int n;
        n = 0;
        WDATA  = d;
        WSTRB  = s;
        WVALID = 1'b1;
        while (WREADY !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) fail_timeout("w_timeout");
        @(negedge clock);
        WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [11:0] a);
        int n;
        n = 0;
        ARADDR  = a;
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40) fail_timeout("ar_timeout");
        @(negedge clock);
        ARVALID = 1'b0;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [7:0] d, input logic s,
                            input logic [1:0] resp, input string tag);
        fork
            send_aw(a);
            send_w(d, s);
        join
        check_output({tag, "_bvalid"}, BVALID, 1);
        check_output({tag, "_bresp"}, BRESP, resp);
    endtask

    task automatic do_read(input logic [11:0] a, input logic [7:0] d,
                           input logic [1:0] resp, input string tag);
        send_ar(a);
        check_output({tag, "_rvalid"}, RVALID, 1);
        check_output({tag, "_rdata"}, RDATA, d);
        check_output({tag, "_rresp"}, RRESP, resp);
    endtask

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 3))
            0, 1:    return 12'($urandom_range(0, 15));
            2:       return 12'($urandom_range(0, DEPTH - 1));
            default: return 12'($urandom_range(DEPTH, 4095));
        endcase
    endfunction

    // Random protocol-legal traffic on all five channels at once.
    task automatic apply_stimulus(input int cycles);
        logic aw_prev, w_prev, ar_prev;
        aw_prev = 1'b0;
        w_prev  = 1'b0;
        ar_prev = 1'b0;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            if (!AWVALID || aw_prev) begin
                AWVALID = ($urandom_range(0, 2) != 0);
                AWADDR  = rand_addr();
            end
            if (!WVALID || w_prev) begin
                WVALID = ($urandom_range(0, 2) != 0);
                WDATA  = 8'($urandom_range(0, 255));
                WSTRB  = ($urandom_range(0, 4) != 0);
            end
            if (!ARVALID || ar_prev) begin
                ARVALID = ($urandom_range(0, 2) != 0);
                ARADDR  = rand_addr();
            end
            BREADY  = ($urandom_range(0, 3) != 0);
            RREADY  = ($urandom_range(0, 3) != 0);
            aw_prev = AWREADY;
            w_prev  = WREADY;
            ar_prev = ARREADY;
            @(negedge clock);
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        ARVALID = 1'b0;
        BREADY  = 1'b1;
        RREADY  = 1'b1;
        repeat (6) @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] bresp_hold;
        logic [7:0] rdata_hold;
        logic [1:0] rresp_hold;

        // Reset and ready rise on the first edge after release.
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_output("pre_edge_awready", AWREADY, 0);
        @(negedge clock);
        check_output("post_rst_awready", AWREADY, 1);
        check_output("post_rst_wready", WREADY, 1);
        check_output("post_rst_arready", ARREADY, 1);

        $display("[TB] basic write/read");
        do_write(12'h010, 8'hA5, 1'b1, 2'b00, "t1_wr");
        @(negedge clock);
        do_read(12'h010, 8'hA5, 2'b00, "t1_rd");
        @(negedge clock);

        $display("[TB] AW ahead of W");
        send_aw(12'h020);
        check_output("t2_awready_drop", AWREADY, 0);
        check_output("t2_wready_up", WREADY, 1);
        repeat (3) @(negedge clock);
        check_output("t2_no_early_b", BVALID, 0);
        send_w(8'h3C, 1'b1);
        check_output("t2_bvalid", BVALID, 1);
        check_output("t2_bresp", BRESP, 0);
        @(negedge clock);
        do_read(12'h020, 8'h3C, 2'b00, "t2_rd");
        @(negedge clock);

        $display("[TB] decode error");
        do_write(12'h000, 8'h11, 1'b1, 2'b00, "t3_base");
        @(negedge clock);
        do_write(12'h800, 8'hFF, 1'b1, 2'b11, "t3_wr");
        @(negedge clock);
        do_read(12'h800, 8'h00, 2'b11, "t3_rd");
        @(negedge clock);
        do_read(12'h000, 8'h11, 2'b00, "t3_alias");
        @(negedge clock);

        $display("[TB] strobe and read-before-write");
        do_write(12'h005, 8'h12, 1'b1, 2'b00, "t5_init");
        @(negedge clock);
        do_write(12'h005, 8'h77, 1'b0, 2'b00, "t5_nostrb");
        @(negedge clock);
        do_read(12'h005, 8'h12, 2'b00, "t5_rd");
        @(negedge clock);
        fork
            send_aw(12'h005);
            send_w(8'h99, 1'b1);
            send_ar(12'h005);
        join
        check_output("t5_same_bvalid", BVALID, 1);
        check_output("t5_same_old", RDATA, 8'h12);
        @(negedge clock);
        do_read(12'h005, 8'h99, 2'b00, "t5_new");
        @(negedge clock);

        $display("[TB] backpressure");
        BREADY = 1'b0;
        RREADY = 1'b0;
        do_write(12'h030, 8'h5A, 1'b1, 2'b00, "t4_wr");
        do_read(12'h010, 8'hA5, 2'b00, "t4_rd");
        bresp_hold = BRESP;
        rdata_hold = RDATA;
        rresp_hold = RRESP;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_output("t4_bvalid_hold", BVALID, 1);
            check_output("t4_rvalid_hold", RVALID, 1);
            check_output("t4_bresp_hold", BRESP, bresp_hold);
            check_output("t4_rdata_hold", RDATA, rdata_hold);
            check_output("t4_rresp_hold", RRESP, rresp_hold);
            check_output("t4_awready_low", AWREADY, 0);
            check_output("t4_wready_low", WREADY, 0);
            check_output("t4_arready_low", ARREADY, 0);
        end
        BREADY = 1'b1;
        RREADY = 1'b1;
        @(negedge clock);
        check_output("t4_awready_back", AWREADY, 1);
        check_output("t4_wready_back", WREADY, 1);
        check_output("t4_arready_back", ARREADY, 1);
        check_output("t4_bvalid_done", BVALID, 0);
        check_output("t4_rvalid_done", RVALID, 0);

        $display("[TB] reset with responses pending");
        BREADY = 1'b0;
        RREADY = 1'b0;
        do_write(12'h040, 8'h66, 1'b1, 2'b00, "t6_wr");
        do_read(12'h030, 8'h5A, 2'b00, "t6_rd");
        #2;
        reset = 1'b1;
        #1;
        check_output("t6_async_bvalid", BVALID, 0);
        check_output("t6_async_rvalid", RVALID, 0);
        check_output("t6_async_awready", AWREADY, 0);
        check_output("t6_async_wready", WREADY, 0);
        check_output("t6_async_arready", ARREADY, 0);
        check_output("t6_async_bresp", BRESP, 0);
        check_output("t6_async_rresp", RRESP, 0);
        check_output("t6_async_rdata", RDATA, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        BREADY = 1'b1;
        RREADY = 1'b1;
        @(negedge clock);
        check_output("t6_awready_back", AWREADY, 1);
        check_output("t6_arready_back", ARREADY, 1);
        check_output("t6_no_stale_b", BVALID, 0);
        check_output("t6_no_stale_r", RVALID, 0);
        repeat (3) @(negedge clock);
        do_read(12'h040, 8'h66, 2'b00, "t6_kept");
        @(negedge clock);

        $display("[TB] random traffic");
        apply_stimulus(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
